dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 16-bit data, synchronous write, one-cycle registered read) among NUM_CORES matrix-multiply cores.
- Each core issues one read or write through a req/ack handshake.
- The arbiter grants cores in round-robin order, drives the memory port from registers, and returns read data with a one-cycle ack pulse.
- Sits between the core array and data_memory_mod in the multi-core top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 8, data memory address width.
- DATA_W, 16, data memory word width.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_CORES  per-core access request, bit i = core i.
- req_write_en  input  NUM_CORES  per-core access type, 1 = write, 0 = read.
- req_addr  input  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W].
- req_datain  input  NUM_CORES*DATA_W  per-core write data, packed the same way.
- grant  output  NUM_CORES  one-hot; marks the core owning the memory port.
- ack  output  NUM_CORES  one-hot, one-cycle pulse when the access completes.
- rdata  output  DATA_W  read data; valid in the ack cycle and held until the next read completes.
- mem_write_en  output  1  to memory write_en0.
- mem_addr  output  ADDR_W  to memory addr0.
- mem_datain  output  DATA_W  to memory datain0.
- mem_dataout  input  DATA_W  from memory dataout0.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset, asynchronous: all outputs go to 0 immediately, including grant, ack, rdata, mem_write_en, mem_addr, mem_datain and busy.
  - state <= IDLE; rr_last <= NUM_CORES-1, so core 0 has first priority.
- All outputs are registered. There is no combinational path from req to any output.
- FSM states and transitions:
  - IDLE: if any req bit is high, select winner g = first set bit searching cyclically from rr_last+1.
    - Latch req_addr[g], req_datain[g] and req_write_en[g] into mem_addr, mem_datain and mem_write_en.
    - Set grant = 1<<g, set rr_last <= g, go to ISSUE.
    - With no req, stay in IDLE; mem_write_en stays 0.
  - ISSUE: the memory samples the port at the end of this cycle. mem_write_en <= 0 at the exit edge. Go to READ.
  - READ: memory output is valid this cycle. At the exit edge:
    - if the access was a read, rdata <= mem_dataout;
    - ack <= grant; go to RESP.
  - RESP: ack is high for exactly this one cycle. At the exit edge: ack <= 0, grant <= 0, go to IDLE.
- Transaction timing:
  - Fixed 3-cycle latency from the IDLE acceptance edge to the ack-high cycle.
  - Throughput is one access per 4 cycles.
  - mem_addr and mem_datain are held until the next acceptance.
- Requester rules:
  - Hold req, address, type and data stable from assertion until ack is seen.
  - Drop req at the edge that ends the ack cycle.
  - Back-to-back requests by the same core are allowed. Req is resampled in the following IDLE cycle.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,...,N-1,0. No core waits more than NUM_CORES transactions.
- Changes to req while not in IDLE are ignored. A new req is considered only in IDLE.
- Writes: rdata is unchanged and ack still pulses.
- Reset asserted mid-transaction: the transaction is aborted with no ack. A write is guaranteed not to occur only if reset asserts before the ISSUE-cycle edge. Cores must reissue after reset.

Test Plan:
- Single read: after reset, core 1 reads addr 0x05 with mem[0x05]=16'h1234 → grant=4'b0010 one cycle after req is sampled; ack[1] pulses 3 cycles after acceptance; rdata=16'h1234; mem_write_en stays 0.
- Single write then read: core 2 writes 16'hBEEF to 0x10, then core 2 reads 0x10 → one-cycle mem_write_en pulse with mem_addr=0x10; read returns 16'hBEEF.
- Round robin: all four cores request reads continuously → grant order 0,1,2,3,0,1; ack every 4 cycles; each core acked exactly once per 16 cycles.
- Priority after the last grant: rr_last=2, cores 0 and 3 request simultaneously → core 3 granted first, then core 0.
- Mid-flight reset: assert reset during READ for a core-0 read → ack, grant, mem_write_en and busy are 0 immediately; after release, an idle arbiter with rr_last=3 grants core 0 first.
- Write abort: assert reset in the same cycle as IDLE acceptance of a core-3 write to 0x20 → mem[0x20] unchanged, no ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
// Each granted access runs IDLE -> ISSUE -> READ -> RESP, with every output registered.
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          req_write_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   req_datain,
    output logic [NUM_CORES-1:0]          grant,
    output logic [NUM_CORES-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_write_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_datain,
    input  logic [DATA_W-1:0]             mem_dataout,
    output logic                          busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_last_q, rr_last_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      datain_q, datain_d;
    logic                   is_write_q, is_write_d;
    logic                   busy_q, busy_d;

    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_we_s;
    logic [ADDR_W-1:0]      win_addr_s;
    logic [DATA_W-1:0]      win_data_s;
    int                     rank_s;
    int                     best_rank_s;

    // Winner search: rank each requester by its cyclic distance after rr_last, keep the lowest.
    always_comb begin
        win_idx_s   = '0;
        win_we_s    = 1'b0;
        win_addr_s  = '0;
        win_data_s  = '0;
        best_rank_s = NUM_CORES;
        rank_s      = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rank_s = (i + NUM_CORES - 1 - int'(rr_last_q)) % NUM_CORES;
            if (req[i] && (rank_s < best_rank_s)) begin
                best_rank_s = rank_s;
                win_idx_s   = IDX_W'(i);
                win_we_s    = req_write_en[i];
                win_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
                win_data_s  = req_datain[i*DATA_W +: DATA_W];
            end else begin
                best_rank_s = best_rank_s;
            end
        end
    end

    // Next-state and next-output logic for the four-phase access sequence.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        grant_d    = grant_q;
        ack_d      = ack_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        addr_d     = addr_q;
        datain_d   = datain_q;
        is_write_d = is_write_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    addr_d     = win_addr_s;
                    datain_d   = win_data_s;
                    we_d       = win_we_s;
                    is_write_d = win_we_s;
                    grant_d    = ONE_HOT0 << win_idx_s;
                    rr_last_d  = win_idx_s;
                    state_d    = ISSUE;
                end else begin
                    we_d = 1'b0;
                end
            end
            ISSUE: begin
                we_d    = 1'b0;
                state_d = READ;
            end
            READ: begin
                if (!is_write_q) begin
                    rdata_d = mem_dataout;
                end else begin
                    rdata_d = rdata_q;
                end
                ack_d   = grant_q;
                state_d = RESP;
            end
            RESP: begin
                ack_d   = '0;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                ack_d   = '0;
                grant_d = '0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset leaves core 0 with first priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_last_q  <= LAST_IDX;
            grant_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            datain_q   <= '0;
            is_write_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            datain_q   <= datain_d;
            is_write_q <= is_write_d;
            busy_q     <= busy_d;
        end
    end

    assign grant        = grant_q;
    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign mem_write_en = we_q;
    assign mem_addr     = addr_q;
    assign mem_datain   = datain_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req, req_write_en;
    logic [31:0] req_addr;
    logic [63:0] req_datain;
    logic [3:0]  grant, ack;
    logic [15:0] rdata;
    logic        mem_write_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;
    logic        busy;

    logic [15:0] tb_mem [256];
    logic [15:0] ref_mem [256];
    logic        preload_en;
    logic [7:0]  preload_addr;
    logic [15:0] preload_val;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_write_en (req_write_en),
        .req_addr     (req_addr),
        .req_datain   (req_datain),
        .grant        (grant),
        .ack          (ack),
        .rdata        (rdata),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .mem_dataout  (mem_dataout),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Single-port memory: synchronous write, registered read.
    always @(posedge clock) begin
        if (preload_en) tb_mem[preload_addr] <= preload_val;
        else if (mem_write_en) tb_mem[mem_addr] <= mem_datain;
        mem_dataout <= tb_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_core(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
        req_write_en[i]       = we;
        req_addr[i*8 +: 8]    = a;
        req_datain[i*16 +: 16] = d;
        req[i]                = 1'b1;
    endtask

    typedef struct {
        int          core;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  exp_grant;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic do_txn(input vec_t v);
        set_core(v.core, v.we, v.addr, v.data);
        @(posedge clock); #1;
        chk("txn_grant", 32'(grant), 32'(v.exp_grant));
        chk("txn_busy", 32'(busy), 32'd1);
        chk("txn_addr", 32'(mem_addr), 32'(v.addr));
        chk("txn_datain", 32'(mem_datain), 32'(v.data));
        chk("txn_we", 32'(mem_write_en), 32'(v.we));
        chk("txn_ack_early", 32'(ack), 32'd0);
        if (v.we) ref_mem[v.addr] = v.data;
        @(posedge clock); #1;
        chk("txn_we_drop", 32'(mem_write_en), 32'd0);
        chk("txn_grant_hold", 32'(grant), 32'(v.exp_grant));
        if (v.we) chk("txn_mem_written", 32'(tb_mem[v.addr]), 32'(v.data));
        @(posedge clock); #1;
        chk("txn_ack", 32'(ack), 32'(v.exp_grant));
        chk("txn_rdata", 32'(rdata), 32'(v.exp_rdata));
        @(posedge clock); #1;
        req[v.core] = 1'b0;
        chk("txn_ack_end", 32'(ack), 32'd0);
        chk("txn_grant_end", 32'(grant), 32'd0);
        chk("txn_busy_end", 32'(busy), 32'd0);
    endtask

    // reference model state
    bit          have_txn;
    int          s_edge, ref_last, t_core;
    logic        t_we;
    logic [7:0]  t_addr;
    logic [15:0] t_data, t_rd;
    logic [7:0]  exp_addr;
    logic [15:0] exp_datain, exp_rdata;
    logic [3:0]  exp_grant, exp_ack, done_pend;

    initial begin
        logic [7:0]  rr_addr [4];
        int          ack_cnt [4];
        logic [15:0] old20;
        int          d;
        bit          in_txn;

        rr_addr = '{8'h05, 8'h10, 8'hFF, 8'h00};
        vecs[0] = '{1, 1'b0, 8'h05, 16'h0000, 4'b0010, 16'h1234};
        vecs[1] = '{2, 1'b1, 8'h10, 16'hBEEF, 4'b0100, 16'h1234};
        vecs[2] = '{2, 1'b0, 8'h10, 16'h1111, 4'b0100, 16'hBEEF};
        vecs[3] = '{0, 1'b1, 8'hFF, 16'h00A5, 4'b0001, 16'hBEEF};
        vecs[4] = '{3, 1'b0, 8'hFF, 16'h2222, 4'b1000, 16'h00A5};
        vecs[5] = '{3, 1'b1, 8'h00, 16'h7777, 4'b1000, 16'h00A5};
        vecs[6] = '{2, 1'b0, 8'h00, 16'h3333, 4'b0100, 16'h7777};

        reset = 1'b1; req = '0; req_write_en = '0; req_addr = '0; req_datain = '0;
        preload_en = 1'b0; preload_addr = '0; preload_val = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_we", 32'(mem_write_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_datain", 32'(mem_datain), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        for (int a = 0; a < 256; a++) begin
            preload_en   = 1'b1;
            preload_addr = 8'(a);
            preload_val  = (a == 5) ? 16'h1234 : {8'(a), ~8'(a)};
            ref_mem[a]   = preload_val;
            @(posedge clock); #1;
        end
        preload_en = 1'b0;
        chk("idle_no_write", 32'(mem_write_en), 32'd0);

        for (int v = 0; v < 7; v++) do_txn(vecs[v]);

        // rr_last is now 2: core 3 must beat core 0
        set_core(0, 1'b0, 8'h05, 16'h0);
        set_core(3, 1'b0, 8'h10, 16'h0);
        @(posedge clock); #1;
        chk("prio_first", 32'(grant), 32'b1000);
        @(posedge clock); @(posedge clock); #1;
        chk("prio_first_ack", 32'(ack), 32'b1000);
        chk("prio_first_rdata", 32'(rdata), 32'hBEEF);
        @(posedge clock); #1;
        req[3] = 1'b0;
        @(posedge clock); #1;
        chk("prio_second", 32'(grant), 32'b0001);
        @(posedge clock); @(posedge clock); #1;
        chk("prio_second_ack", 32'(ack), 32'b0001);
        chk("prio_second_rdata", 32'(rdata), 32'h1234);
        @(posedge clock); #1;
        req[0] = 1'b0;

        // reset in the READ cycle of a core-0 read
        set_core(0, 1'b0, 8'h10, 16'h0);
        @(posedge clock); @(posedge clock); #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_ack", 32'(ack), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_we", 32'(mem_write_en), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        req = '0;
        @(posedge clock); #1;
        chk("mid_no_ack", 32'(ack), 32'd0);
        reset = 1'b0;

        // all cores continuously requesting
        for (int i = 0; i < 4; i++) begin
            set_core(i, 1'b0, rr_addr[i], 16'h0);
            ack_cnt[i] = 0;
        end
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            chk("rr_grant", 32'(grant), 32'(4'b0001 << (n % 4)));
            @(posedge clock); @(posedge clock); #1;
            chk("rr_ack", 32'(ack), 32'(4'b0001 << (n % 4)));
            chk("rr_rdata", 32'(rdata), 32'(ref_mem[rr_addr[n % 4]]));
            for (int i = 0; i < 4; i++) if (n < 4 && ack[i]) ack_cnt[i]++;
            @(posedge clock); #1;
            chk("rr_ack_pulse", 32'(ack), 32'd0);
        end
        req = '0;
        for (int i = 0; i < 4; i++) chk("rr_once_per_16", 32'(ack_cnt[i]), 32'd1);
        @(posedge clock); #1;

        // reset right after accepting a core-3 write
        old20 = ref_mem[8'h20];
        set_core(3, 1'b1, 8'h20, 16'hDEAD);
        @(posedge clock); #1;
        chk("abort_grant", 32'(grant), 32'b1000);
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(mem_write_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            chk("abort_no_ack", 32'(ack), 32'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        chk("abort_mem", 32'(tb_mem[8'h20]), 32'(old20));

        // randomized run against the transaction-level model
        have_txn = 1'b0; s_edge = 0; ref_last = 3; t_core = 0; t_we = 1'b0;
        t_addr = '0; t_data = '0; t_rd = '0;
        exp_addr = '0; exp_datain = '0; exp_rdata = '0; done_pend = '0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clock); #1;
            if ((!have_txn || c >= s_edge + 4) && req != 4'b0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (req[(ref_last + k) % 4] && !(have_txn && s_edge == c)) begin
                        t_core   = (ref_last + k) % 4;
                        have_txn = 1'b1;
                        s_edge   = c;
                    end
                end
                ref_last   = t_core;
                t_we       = req_write_en[t_core];
                t_addr     = req_addr[t_core*8 +: 8];
                t_data     = req_datain[t_core*16 +: 16];
                exp_addr   = t_addr;
                exp_datain = t_data;
                if (t_we) ref_mem[t_addr] = t_data;
                else t_rd = ref_mem[t_addr];
            end
            d         = c - s_edge;
            in_txn    = have_txn && (d <= 2);
            exp_grant = in_txn ? (4'b0001 << t_core) : 4'b0000;
            exp_ack   = (have_txn && d == 2) ? (4'b0001 << t_core) : 4'b0000;
            if (have_txn && d == 2 && !t_we) exp_rdata = t_rd;
            chk("rnd_grant", 32'(grant), 32'(exp_grant));
            chk("rnd_ack", 32'(ack), 32'(exp_ack));
            chk("rnd_busy", 32'(busy), 32'(in_txn));
            chk("rnd_we", 32'(mem_write_en), 32'(have_txn && d == 0 && t_we));
            chk("rnd_addr", 32'(mem_addr), 32'(exp_addr));
            chk("rnd_datain", 32'(mem_datain), 32'(exp_datain));
            chk("rnd_rdata", 32'(rdata), 32'(exp_rdata));
            for (int i = 0; i < 4; i++) begin
                if (done_pend[i]) begin
                    req[i] = 1'b0;
                    done_pend[i] = 1'b0;
                end
                if (exp_ack[i]) done_pend[i] = 1'b1;
                if (c < 780 && !req[i] && !done_pend[i] && $urandom_range(0, 2) == 0)
                    set_core(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
            end
        end
        req = '0;
        repeat (2) @(posedge clock);
        #1;
        for (int a = 0; a < 256; a++) chk("final_mem", 32'(tb_mem[a]), 32'(ref_mem[a]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
